ps2_host_tx: RTL
================

# ps2_host_tx

Host-to-device PS/2 transmitter. It sends one command byte to the keyboard (LED set 0xED, reset 0xFF, enable 0xF4, and so on) over the same open-drain PS2_clk/PS2_data pair that the scancode receiver listens on. It sits in the MemoryUnit I/O space next to the PS/2 receiver, which it complements. While it owns the bus, it drives the pins low through output-enables only.

## Interface
Parameters:
- CLK_HZ, 50000000: system clock frequency in Hz.
- INHIBIT_US, 100: time the clock line is held low before the request-to-send.
- TIMEOUT_US, 15000: limit from clock release to frame completion.

Ports:
- clk, input, 1: system clock, 50 MHz.
- nreset, input, 1: asynchronous, active-low reset.
- start, input, 1: one-cycle pulse that requests transmission of `data`. Ignored while `busy` is high.
- data, input, 8: command byte, latched on an accepted `start`.
- busy, output, 1: high from the accepted `start` until `done`.
- done, output, 1: one-cycle pulse marking the end of a frame, whether it succeeded or failed.
- ack_ok, output, 1: device acknowledged the frame. Valid with `done`, held until the next accepted `start`.
- error, output, 1: timeout occurred. Valid with `done`, held until the next accepted `start`.
- PS2_clk, input, 1: raw PS/2 clock pin; the block synchronizes it internally.
- PS2_data, input, 1: raw PS/2 data pin; the block synchronizes it internally.
- PS2_clk_oe, output, 1: 1 drives the clock pin low, 0 releases it.
- PS2_data_oe, output, 1: 1 drives the data pin low, 0 releases it.

## Operation
- Each pin passes through a 2-flop synchronizer plus a previous-value register. A falling edge (fe) is prev=1 and cur=0.
- Parity is odd: parity = ~^data.
- The shift frame is {stop=1, parity, data[7:0]}, sent LSB first. A data-line value of 1 means `PS2_data_oe` = 0.

State machine:
- IDLE
  - Outputs: `PS2_clk_oe` = 0, `PS2_data_oe` = 0.
  - On `start`: latch the frame, clear `ack_ok`/`error`, set `busy`, go to INHIBIT.
- INHIBIT
  - Outputs: `PS2_clk_oe` = 1.
  - Count N_INH = CLK_HZ/1000000*INHIBIT_US cycles, then go to REQ.
- REQ
  - Outputs: `PS2_clk_oe` = 1, `PS2_data_oe` = 1 (start bit).
  - After exactly 1 cycle go to SEND with `PS2_clk_oe` = 0.
  - Clear the bit counter and the timeout counter.
- SEND
  - On each fe: drive the next frame bit onto the data line and increment the bit counter.
  - Falling edges 1–8 send data, fe 9 sends parity, fe 10 sends stop (data released).
  - After fe 10 go to ACK.
- ACK
  - On the next fe: sample synchronized data. 0 sets `ack_ok` = 1, 1 leaves `ack_ok` = 0.
  - Go to WAIT_IDLE.
- WAIT_IDLE
  - Wait until both synchronized lines are 1.
  - Then pulse `done`, clear `busy`, go to IDLE.
- Timeout: the counter runs in SEND, ACK and WAIT_IDLE. When it reaches N_TO = CLK_HZ/1000000*TIMEOUT_US:
  - release both oe outputs;
  - set `error` = 1, `ack_ok` = 0;
  - pulse `done`, return to IDLE.
- Counter widths are $clog2 of the terminal count plus 1. Counters saturate and never wrap.
- Device activity on the pins during INHIBIT or REQ is ignored.
- A `start` in the same cycle as `done` is ignored; the next `start` is accepted from IDLE.

## Timing
- Reset values: `busy`, `done`, `ack_ok`, `error`, `PS2_clk_oe`, `PS2_data_oe` are all 0. The state is IDLE.
- `nreset` asserted mid-frame releases both pins immediately (asynchronous) and produces no `done` pulse.
- `start` to `PS2_clk_oe` = 1: 1 cycle. INHIBIT lasts exactly N_INH cycles. REQ lasts exactly 1 cycle.
- Pin falling edge to fe detect: 3 cycles. fe to `PS2_data_oe` update: 1 further cycle. This fits well inside the device's ~30–50 µs clock-low phase.
- `done` is a 1-cycle pulse; `busy` falls in the same cycle.

## Configuration
- PS2_HOST_TX_TIMEOUT_EN defined: the timeout counter and `error` path are built as described.
- PS2_HOST_TX_TIMEOUT_EN undefined:
  - no timeout counter is built;
  - `error` is tied to 0;
  - the FSM waits indefinitely for device clocks.

## Test plan
All scenarios use CLK_HZ=1000000 and INHIBIT_US=100, giving N_INH=100.

1. `start`, `data`=0xED, device model clocking at 12 kHz with ack:
   - `PS2_clk_oe` is high for 100 cycles;
   - the model receives bits 1,0,1,1,0,1,1,1 (LSB first), parity 1, stop 1;
   - then `done` with `ack_ok`=1, `error`=0.
2. `data`=0xF4: the model sees parity 0; `ack_ok`=1. `data`=0x00: parity 1.
3. Device model omits the ack (data stays high on fe 11): `done`, `ack_ok`=0, `error`=0.
4. With PS2_HOST_TX_TIMEOUT_EN and TIMEOUT_US=200, the device never clocks:
   - `done` occurs 200 cycles after REQ exits;
   - `error`=1, both oe outputs are 0.
5. `start` pulsed again mid-frame: ignored, and the frame bits are unchanged. `nreset` asserted after fe 5: both oe outputs are 0 in the same cycle, `busy`=0, no `done`.

Source files
------------

// File: rtl/ps2_host_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ps2_host_tx                                                     |
// | Purpose  : PS/2 host-to-device command transmitter (open-drain via oe).    |
// | Options  : PS2_HOST_TX_TIMEOUT_EN builds the frame timeout / error path.   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module ps2_host_tx #(
  parameter int CLK_HZ     = 50000000,
  parameter int INHIBIT_US = 100,
  parameter int TIMEOUT_US = 15000
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       error,
  input  logic       PS2_clk,
  input  logic       PS2_data,
  output logic       PS2_clk_oe,
  output logic       PS2_data_oe
);

  localparam int N_INH = CLK_HZ / 1000000 * INHIBIT_US;
  localparam int INH_W = $clog2(N_INH) + 1;
  localparam int N_BITS = 10;
  localparam int BIT_W = $clog2(N_BITS) + 1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INHIBIT   = 3'd1,
    S_REQ       = 3'd2,
    S_SEND      = 3'd3,
    S_ACK       = 3'd4,
    S_WAIT_IDLE = 3'd5
  } state_t;

  state_t             state_q;
  logic [2:0]         clk_sync_q;
  logic [1:0]         data_sync_q;
  logic [9:0]         frame_q;
  logic [BIT_W-1:0]   bit_cnt_q;
  logic [INH_W-1:0]   inh_cnt_q;
  logic               busy_q, done_q, ack_q, err_q, clk_oe_q, data_oe_q;
  logic               clk_cur, clk_fe, data_cur, active, to_hit;

  // Lines idle high, so the synchronizers reset to 1 to avoid a false edge.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      clk_sync_q  <= 3'b111;
      data_sync_q <= 2'b11;
    end else begin
      clk_sync_q  <= {clk_sync_q[1:0], PS2_clk};
      data_sync_q <= {data_sync_q[0], PS2_data};
    end
  end

  assign clk_cur  = clk_sync_q[1];
  assign clk_fe   = clk_sync_q[2] & ~clk_sync_q[1];
  assign data_cur = data_sync_q[1];
  assign active   = (state_q == S_SEND) || (state_q == S_ACK) || (state_q == S_WAIT_IDLE);

`ifdef PS2_HOST_TX_TIMEOUT_EN
  localparam int N_TO = CLK_HZ / 1000000 * TIMEOUT_US;
  localparam int TO_W = $clog2(N_TO) + 1;
  logic [TO_W-1:0] to_cnt_q;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      to_cnt_q <= '0;
    end else if (state_q == S_REQ) begin
      to_cnt_q <= '0;
    end else if (active && (to_cnt_q != TO_W'(N_TO))) begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end
  end

  // Fires on the edge where the counter would reach the terminal count.
  assign to_hit = active && (to_cnt_q == TO_W'(N_TO - 1));
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q   <= S_IDLE;
      frame_q   <= '0;
      bit_cnt_q <= '0;
      inh_cnt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          clk_oe_q  <= 1'b0;
          data_oe_q <= 1'b0;
          // done_q high means the previous frame ended this cycle.
          if (start && !done_q) begin
            frame_q   <= {1'b1, ~^data, data};
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b1;
            clk_oe_q  <= 1'b1;
            inh_cnt_q <= '0;
            state_q   <= S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          if (inh_cnt_q == INH_W'(N_INH - 1)) begin
            data_oe_q <= 1'b1;
            state_q   <= S_REQ;
          end else begin
            inh_cnt_q <= inh_cnt_q + 1'b1;
          end
        end
        S_REQ: begin
          clk_oe_q  <= 1'b0;
          bit_cnt_q <= '0;
          state_q   <= S_SEND;
        end
        S_SEND: begin
          if (clk_fe) begin
            data_oe_q <= ~frame_q[0];
            frame_q   <= {1'b1, frame_q[9:1]};
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == BIT_W'(N_BITS - 1)) begin
              state_q <= S_ACK;
            end
          end
        end
        S_ACK: begin
          if (clk_fe) begin
            ack_q   <= ~data_cur;
            state_q <= S_WAIT_IDLE;
          end
        end
        S_WAIT_IDLE: begin
          if (clk_cur && data_cur) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
      if (to_hit) begin
        clk_oe_q  <= 1'b0;
        data_oe_q <= 1'b0;
        err_q     <= 1'b1;
        ack_q     <= 1'b0;
        done_q    <= 1'b1;
        busy_q    <= 1'b0;
        state_q   <= S_IDLE;
      end
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign ack_ok      = ack_q;
  assign error       = err_q;
  assign PS2_clk_oe  = clk_oe_q;
  assign PS2_data_oe = data_oe_q;

endmodule
`default_nettype wire
